pipelined_fp_addsub: RTL and testbench

Parametrised successor of the team's fixed FP32 pipelined adder.
- Adds or subtracts two IEEE-754-style floats of configurable exponent/mantissa width.
- Uses a valid/ready handshake with full backpressure instead of per-stage status flags.
- Rounds to nearest, ties to even (RNE), handles special values, and reports exception flags.
- Sits between operand-producing logic and any consumer that can stall.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_lzc.sv | 15 +
 rtl/pipelined_fp_addsub.sv | 153 +++++++++++++++
 tb/tb_pipelined_fp_addsub.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, operand classes, pipeline control payload and special-value constructors
package fp_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

    typedef struct packed {
        logic vld;
        logic sgn;
        logic sub;
        logic nv;
        logic inf;
        logic isgn;
        logic zz;
        logic zsgn;
    } fp_ctl_t;

    function automatic logic [63:0] fp_zero(input int ew, input int mw, input logic s);
        return 64'(s) << (ew + mw);
    endfunction

    function automatic logic [63:0] fp_inf(input int ew, input int mw, input logic s);
        return fp_zero(ew, mw, s) | (((64'd1 << ew) - 64'd1) << mw);
    endfunction

    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        return fp_inf(ew, mw, 1'b0) | (64'd1 << (mw - 1));
    endfunction

    function automatic fp_class_t fp_classify(input logic ez, input logic eo, input logic fz);
        return ez ? ZERO : !eo ? NORM : fz ? INF : NAN;
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter, returns W for an all-zero vector
module fp_lzc #(
    parameter int W = 27
) (
    input  logic [W-1:0]             vec,
    output logic [$clog2(W+1)-1:0]   cnt
);
    localparam int CW = $clog2(W + 1);

    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (vec[i]) cnt = CW'(W - 1 - i);
    end
endmodule

// File: rtl/pipelined_fp_addsub.sv
// pipelined_fp_addsub: 4-stage RNE float add/sub with flush-to-zero and valid/ready backpressure
module pipelined_fp_addsub
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W,
    parameter int FTZ   = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       op_i,
    input  logic [EXP_W+MAN_W:0]       a_i,
    input  logic [EXP_W+MAN_W:0]       b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [EXP_W+MAN_W:0]       sum_o,
    output logic [2:0]                 flags_o
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;
    localparam int RW = MAN_W + 1;
    localparam int LW = $clog2(SW + 1);
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));

    typedef struct packed {
        fp_ctl_t            c;
        logic [EXP_W-1:0]   ex;
        logic [EXP_W-1:0]   d;
        logic [MAN_W:0]     mx;
        logic [MAN_W:0]     my;
    } s1_t;

    typedef struct packed {
        fp_ctl_t            c;
        logic [EXP_W-1:0]   ex;
        logic [SW-1:0]      xs;
        logic [SW-1:0]      ys;
    } s2_t;

    typedef struct packed {
        fp_ctl_t            c;
        logic [EXP_W-1:0]   ex;
        logic [SW:0]        sum;
    } s3_t;

    s1_t s1, n1;
    s2_t s2, n2;
    s3_t s3, n3;
    logic adv;
    logic sa, sb, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [MAN_W:0] ma, mb;
    fp_class_t ca, cb;
    logic [SW-1:0] ye, ysh, ymask;
    logic [LW-1:0] lz;
    logic [SW-1:0] nrm;
    logic [RW-1:0] rnd;
    logic fin, ovf, unf;
    int ef;
    logic [W-1:0] sum_n;
    logic [2:0] flags_n;

    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        sa   = a_i[W-1];
        sb   = b_i[W-1] ^ op_i;
        ea   = a_i[W-2:MAN_W];
        eb   = b_i[W-2:MAN_W];
        fa   = a_i[MAN_W-1:0];
        fb   = b_i[MAN_W-1:0];
        ca   = fp_classify(ea == '0 && (FTZ != 0 || fa == '0), &ea, fa == '0);
        cb   = fp_classify(eb == '0 && (FTZ != 0 || fb == '0), &eb, fb == '0);
        ma   = ca == NORM ? {1'b1, fa} : '0;
        mb   = cb == NORM ? {1'b1, fb} : '0;
        swap = {eb, fb} > {ea, fa};
        n1.c.vld  = in_valid_i;
        n1.c.sgn  = swap ? sb : sa;
        n1.c.sub  = sa ^ sb;
        n1.c.nv   = ca == NAN || cb == NAN || (ca == INF && cb == INF && (sa ^ sb));
        n1.c.inf  = ca == INF || cb == INF;
        n1.c.isgn = ca == INF ? sa : sb;
        n1.c.zz   = ca == ZERO && cb == ZERO;
        n1.c.zsgn = sa & sb;
        n1.ex     = swap ? eb : ea;
        n1.d      = swap ? eb - ea : ea - eb;
        n1.mx     = swap ? mb : ma;
        n1.my     = swap ? ma : mb;
    end

    // everything shifted past the sticky position folds into bit 0
    always_comb begin
        ye    = {s1.my, 3'b000};
        ysh   = ye >> s1.d;
        ymask = ~({SW{1'b1}} << s1.d);
        n2.c  = s1.c;
        n2.ex = s1.ex;
        n2.xs = {s1.mx, 3'b000};
        n2.ys = 32'(s1.d) >= MAN_W + 3 ? {{(SW-1){1'b0}}, |s1.my}
                                       : {ysh[SW-1:1], ysh[0] | (|(ye & ymask))};
    end

    always_comb begin
        n3.c   = s2.c;
        n3.ex  = s2.ex;
        n3.sum = s2.c.sub ? {1'b0, s2.xs} - {1'b0, s2.ys} : {1'b0, s2.xs} + {1'b0, s2.ys};
    end

    fp_lzc #(.W(SW)) u_lzc (
        .vec (s3.sum[SW-1:0]),
        .cnt (lz)
    );

    // nrm's top bit is the hidden one, so it is clear only for an exact zero sum
    always_comb begin
        nrm     = s3.sum[SW] ? {s3.sum[SW:2], |s3.sum[1:0]} : s3.sum[SW-1:0] << lz;
        rnd     = {1'b0, nrm[SW-2:3]} + RW'(nrm[2] & (nrm[1] | nrm[0] | nrm[3]));
        ef      = int'(s3.ex) + (s3.sum[SW] ? 1 : -int'(lz)) + int'(rnd[MAN_W]);
        fin     = !s3.c.nv && !s3.c.inf && !s3.c.zz && nrm[SW-1];
        ovf     = fin && ef >= (1 << EXP_W) - 1;
        unf     = fin && ef <= 0;
        sum_n   = s3.c.nv  ? QNAN
                : s3.c.inf ? W'(fp_inf(EXP_W, MAN_W, s3.c.isgn))
                : s3.c.zz  ? W'(fp_zero(EXP_W, MAN_W, s3.c.zsgn))
                : !fin     ? '0
                : ovf      ? W'(fp_inf(EXP_W, MAN_W, s3.c.sgn))
                : unf      ? W'(fp_zero(EXP_W, MAN_W, s3.c.sgn))
                : {s3.c.sgn, ef[EXP_W-1:0], rnd[MAN_W-1:0]};
        flags_n = s3.c.vld ? {s3.c.nv, ovf, unf} : 3'b000;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1          <= '0;
            s2          <= '0;
            s3          <= '0;
            out_valid_o <= 1'b0;
            sum_o       <= '0;
            flags_o     <= '0;
        end else if (adv) begin
            s1          <= n1;
            s2          <= n2;
            s3          <= n3;
            out_valid_o <= s3.c.vld;
            sum_o       <= sum_n;
            flags_o     <= flags_n;
        end
    end
endmodule

// File: tb/tb_pipelined_fp_addsub.sv
// tb_pipelined_fp_addsub: directed vectors for FP32 and binary16 instances, backpressure and async reset
module tb_pipelined_fp_addsub;
    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic [2:0]  f;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic iv = 1'b0, hv = 1'b0, op = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic ir, ov, hir, hov;
    logic ordy = 1'b1;
    logic [31:0] sum;
    logic [15:0] hsum;
    logic [2:0] fl, hfl;
    int total = 0, bad = 0;
    vec_t vt [18];
    vec_t ht [4];
    logic [31:0] fv [9];
    int got, stale;
    logic [31:0] held;
    logic stalled;

    always #5 clk = ~clk;

    pipelined_fp_addsub u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (iv),
        .in_ready_o  (ir),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (ov),
        .out_ready_i (ordy),
        .sum_o       (sum),
        .flags_o     (fl)
    );

    pipelined_fp_addsub #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (hv),
        .in_ready_o  (hir),
        .op_i        (op),
        .a_i         (a[15:0]),
        .b_i         (b[15:0]),
        .out_valid_o (hov),
        .out_ready_i (1'b1),
        .sum_o       (hsum),
        .flags_o     (hfl)
    );

    task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic run_vec(input logic h, input vec_t v, input string tag);
        int n;
        @(posedge clk); #1;
        op = v.op;
        a  = v.a;
        b  = v.b;
        if (h) hv = 1'b1; else iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        hv = 1'b0;
        n  = 0;
        while (!(h ? hov : ov) && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n + 1), 64'd4);
        chk({tag, "_sum"}, h ? 64'(hsum) : 64'(sum), 64'(v.s));
        chk({tag, "_flg"}, h ? 64'(hfl) : 64'(fl), 64'(v.f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vt = '{
            '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000},
            '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 3'b000},
            '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000},
            '{1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 3'b000},
            '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 3'b000},
            '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100},
            '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100},
            '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000},
            '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 3'b000},
            '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010},
            '{1'b1, 32'h00800000, 32'h00800001, 32'h80000000, 3'b001},
            '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 3'b000},
            '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000},
            '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 3'b000},
            '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 3'b000},
            '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 3'b000},
            '{1'b0, 32'h40400000, 32'hC0400000, 32'h00000000, 3'b000},
            '{1'b0, 32'h3F800000, 32'hBF7FFFFF, 32'h33800000, 3'b000}
        };
        ht = '{
            '{1'b0, 32'h3C00, 32'h3C00, 32'h4000, 3'b000},
            '{1'b0, 32'h7BFF, 32'h7BFF, 32'h7C00, 3'b010},
            '{1'b1, 32'h3C00, 32'h3C00, 32'h0000, 3'b000},
            '{1'b0, 32'h3C00, 32'h4000, 32'h4200, 3'b000}
        };
        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_vld", 64'(ov), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_flg", 64'(fl), 64'd0);
        chk("rst_rdy", 64'(ir), 64'd1);
        chk("rst_hvld", 64'(hov), 64'd0);

        for (int i = 0; i < 18; i++) run_vec(1'b0, vt[i], $sformatf("v%0d", i));
        for (int i = 0; i < 4; i++) run_vec(1'b1, ht[i], $sformatf("h%0d", i));

        got     = 0;
        stalled = 1'b0;
        held    = '0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    int n;
                    @(posedge clk); #1;
                    iv = 1'b1;
                    op = 1'b0;
                    a  = fv[k];
                    b  = fv[0];
                    n  = 0;
                    @(negedge clk);
                    while (!ir && n < 40) begin
                        @(negedge clk);
                        n++;
                    end
                    chk("bp_drv_to", 64'(n < 40), 64'd1);
                end
                @(posedge clk); #1;
                iv = 1'b0;
            end
            begin
                for (int c = 0; c < 40 && got < 8; c++) begin
                    @(posedge clk); #1;
                    ordy = !(c >= 5 && c <= 8);
                    @(negedge clk);
                    if (ov && !ordy) begin
                        chk("bp_in_rdy", 64'(ir), 64'd0);
                        if (stalled) chk("bp_stable", 64'(sum), 64'(held));
                        held    = sum;
                        stalled = 1'b1;
                    end else if (ov) begin
                        chk($sformatf("bp_out%0d", got), 64'(sum), 64'(fv[got + 1]));
                        got++;
                        stalled = 1'b0;
                    end
                end
                chk("bp_count", 64'(got), 64'd8);
            end
        join
        chk("bp_saw_stall", 64'(held), 64'(fv[2]));

        @(posedge clk); #1;
        ordy = 1'b1;
        iv   = 1'b1;
        a    = fv[1];
        b    = fv[0];
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_vld", 64'(ov), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_vld", 64'(ov), 64'd0);
        chk("rst_async_sum", 64'(sum), 64'd0);
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
